// File: rtl/fetch_stage_pipe.sv
// rtl/fetch_stage_pipe.sv - MIPS IF stage: PC, PC+4, redirect mux, loadable IMEM, IF/ID register, HALT freeze
module fetch_stage_pipe #(
   parameter int            NBITS       = 32,
   parameter int            IMEM_DEPTH  = 256,
   parameter logic [5:0]    HALT_OPCODE = 6'h3F,
   localparam int           AW          = $clog2(IMEM_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_enable,
   input  logic             i_writePC,
   input  logic             i_flush,
   input  logic             i_branch_sel,
   input  logic [NBITS-1:0] i_branch_addr,
   input  logic             i_jump,
   input  logic [NBITS-1:0] i_jump_addr,
   input  logic             i_load_en,
   input  logic [AW-1:0]    i_load_addr,
   input  logic [NBITS-1:0] i_load_data,
   output logic [NBITS-1:0] o_current_pc,
   output logic [NBITS-1:0] o_ID_inst,
   output logic [NBITS-1:0] o_ID_next_pc,
   output logic             o_halted
);

   typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

   logic [NBITS-1:0] r_imem [IMEM_DEPTH];
   logic [NBITS-1:0] r_pc;
   logic [NBITS-1:0] r_id_inst;
   logic [NBITS-1:0] r_id_next_pc;
   state_t           r_state;

   logic [NBITS-1:0] w_inst;
   logic [NBITS-1:0] w_pc_plus4;
   logic [NBITS-1:0] w_pc_target;
   logic             w_is_halt;
   logic [NBITS-1:0] w_pc_nxt;
   logic [NBITS-1:0] w_id_inst_nxt;
   logic [NBITS-1:0] w_id_next_pc_nxt;
   state_t           w_state_nxt;

   // Word-addressed read: byte offset and bits above the array range are dropped.
   assign w_inst      = r_imem[r_pc[AW+1:2]];
   assign w_pc_plus4  = r_pc + NBITS'(4);
   // Branch outranks jump; with no redirect the PC simply advances.
   assign w_pc_target = i_branch_sel ? i_branch_addr :
                        i_jump       ? i_jump_addr   : w_pc_plus4;
   assign w_is_halt   = (w_inst[NBITS-1 -: 6] == HALT_OPCODE);

   // Instruction memory load port; never reset, writes even when stepping is disabled.
   always_ff @(posedge clk) begin
      if (i_load_en) begin
         r_imem[i_load_addr] <= i_load_data;
      end
   end

   // Next-state / next-PC / next IF/ID selection with stall > flush > normal priority.
   always_comb begin
      w_pc_nxt         = r_pc;
      w_id_inst_nxt    = r_id_inst;
      w_id_next_pc_nxt = r_id_next_pc;
      w_state_nxt      = r_state;
      if (i_enable) begin
         case (r_state)
            ST_RUN: begin
               if (!i_writePC) begin
                  // Stall: everything holds; ID re-presents any flush/redirect later.
                  w_pc_nxt = r_pc;
               end else if (i_flush) begin
                  // Squashed slot: a HALT word here is discarded and never halts.
                  w_id_inst_nxt    = '0;
                  w_id_next_pc_nxt = '0;
                  w_pc_nxt         = w_pc_target;
               end else begin
                  w_id_inst_nxt    = w_inst;
                  w_id_next_pc_nxt = w_pc_plus4;
                  if (w_is_halt) begin
                     w_state_nxt = ST_HALTED;
                  end else begin
                     w_pc_nxt = w_pc_target;
                  end
               end
            end
            ST_HALTED: begin
               // Drain the pipe behind HALT with bubbles; PC stays frozen.
               w_id_inst_nxt    = '0;
               w_id_next_pc_nxt = '0;
            end
            default: w_state_nxt = ST_RUN;
         endcase
      end
   end

   // PC, IF/ID register and FSM state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc         <= '0;
         r_id_inst    <= '0;
         r_id_next_pc <= '0;
         r_state      <= ST_RUN;
      end else begin
         r_pc         <= w_pc_nxt;
         r_id_inst    <= w_id_inst_nxt;
         r_id_next_pc <= w_id_next_pc_nxt;
         r_state      <= w_state_nxt;
      end
   end

   assign o_current_pc = r_pc;
   assign o_ID_inst    = r_id_inst;
   assign o_ID_next_pc = r_id_next_pc;
   assign o_halted     = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_stage_pipe.sv
// tb/tb_fetch_stage_pipe.sv - self-checking bench for fetch_stage_pipe (vector table, directed corners, random vs model)
module tb_fetch_stage_pipe;
   localparam int AW = 8;
   localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_enable, i_writePC, i_flush, i_branch_sel, i_jump, i_load_en;
   logic [31:0] i_branch_addr, i_jump_addr, i_load_data;
   logic [AW-1:0] i_load_addr;
   logic [31:0] o_current_pc, o_ID_inst, o_ID_next_pc;
   logic        o_halted;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_stage_pipe dut (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_writePC(i_writePC), .i_flush(i_flush),
      .i_branch_sel(i_branch_sel), .i_branch_addr(i_branch_addr), .i_jump(i_jump),
      .i_jump_addr(i_jump_addr), .i_load_en(i_load_en), .i_load_addr(i_load_addr),
      .i_load_data(i_load_data), .o_current_pc(o_current_pc), .o_ID_inst(o_ID_inst),
      .o_ID_next_pc(o_ID_next_pc), .o_halted(o_halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wpc, flush, br;
      logic [31:0] baddr;
      logic        jmp;
      logic [31:0] jaddr;
      logic [31:0] e_pc, e_inst, e_npc;
      logic        e_halt;
   } vec_t;

   vec_t tbl[13];

   // Reference-model state: the architectural view of the IF stage.
   logic [31:0] m_mem [256];
   logic [31:0] m_pc, m_inst, m_npc;
   logic        m_halt;

   function automatic logic [31:0] w(input int i);
      return 32'h0400_0000 + 32'(i) * 32'h101;
   endfunction

   function automatic vec_t mk(input logic wpc, input logic flush, input logic br, input logic [31:0] baddr,
                               input logic jmp, input logic [31:0] jaddr, input logic [31:0] e_pc,
                               input logic [31:0] e_inst, input logic [31:0] e_npc, input logic e_halt);
      vec_t v;
      v.wpc = wpc; v.flush = flush; v.br = br; v.baddr = baddr; v.jmp = jmp; v.jaddr = jaddr;
      v.e_pc = e_pc; v.e_inst = e_inst; v.e_npc = e_npc; v.e_halt = e_halt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] npc, input logic halt);
      chk({tag, ".pc"}, o_current_pc, pc);
      chk({tag, ".inst"}, o_ID_inst, inst);
      chk({tag, ".npc"}, o_ID_next_pc, npc);
      chk({tag, ".halted"}, {31'b0, o_halted}, {31'b0, halt});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      i_enable = 1'b1; i_writePC = 1'b1; i_flush = 1'b0;
      i_branch_sel = 1'b0; i_branch_addr = '0; i_jump = 1'b0; i_jump_addr = '0;
      i_load_en = 1'b0; i_load_addr = '0; i_load_data = '0;
   endtask

   task automatic load_word(input int addr, input logic [31:0] data);
      i_load_en = 1'b1; i_load_addr = AW'(addr); i_load_data = data;
      tick();
      i_load_en = 1'b0;
   endtask

   // One clock edge of the IF stage computed from the architectural rules.
   task automatic model_edge();
      logic [31:0] fetched, target;
      fetched = m_mem[(m_pc >> 2) & 32'hFF];
      target  = i_branch_sel ? i_branch_addr : i_jump ? i_jump_addr : m_pc + 32'd4;
      if (rst) begin
         m_pc = 0; m_inst = 0; m_npc = 0; m_halt = 1'b0;
      end else if (i_enable) begin
         if (m_halt) begin
            m_inst = 0; m_npc = 0;
         end else if (i_writePC) begin
            if (i_flush) begin
               m_inst = 0; m_npc = 0; m_pc = target;
            end else begin
               m_inst = fetched; m_npc = m_pc + 32'd4;
               if (fetched[31:26] == 6'h3F) m_halt = 1'b1;
               else m_pc = target;
            end
         end
      end
      if (i_load_en) m_mem[i_load_addr] = i_load_data;
   endtask

   initial begin
      set_idle();
      rst = 1'b1;
      #1;
      chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);

      // Vector table: each row is applied for one edge from reset release.
      tbl[0]  = mk(1, 0, 0, 0,     0, 0,     32'h04, w(0),  32'h04, 0);
      tbl[1]  = mk(1, 0, 0, 0,     0, 0,     32'h08, w(1),  32'h08, 0);
      tbl[2]  = mk(0, 0, 0, 0,     0, 0,     32'h08, w(1),  32'h08, 0);
      tbl[3]  = mk(0, 1, 1, 32'h40,0, 0,     32'h08, w(1),  32'h08, 0);
      tbl[4]  = mk(1, 0, 0, 0,     0, 0,     32'h0C, w(2),  32'h0C, 0);
      tbl[5]  = mk(1, 0, 0, 0,     0, 0,     32'h10, w(3),  32'h10, 0);
      tbl[6]  = mk(1, 0, 0, 0,     1, 32'h8, 32'h08, w(4),  32'h14, 0);
      tbl[7]  = mk(1, 1, 1, 32'h40,0, 0,     32'h40, 32'h0, 32'h00, 0);
      tbl[8]  = mk(1, 0, 0, 0,     0, 0,     32'h44, w(16), 32'h44, 0);
      tbl[9]  = mk(1, 0, 1, 32'h20,1, 32'h80,32'h20, w(17), 32'h48, 0);
      tbl[10] = mk(0, 0, 1, 32'h20,1, 32'h80,32'h20, w(17), 32'h48, 0);
      tbl[11] = mk(1, 0, 0, 0,     1, 32'h80,32'h80, w(8),  32'h24, 0);
      tbl[12] = mk(1, 0, 0, 0,     0, 0,     32'h84, w(32), 32'h84, 0);

      for (int i = 0; i < 64; i++) load_word(i, w(i));
      chk_all("reset_hold", 32'h0, 32'h0, 32'h0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 13; i++) begin
         i_writePC = tbl[i].wpc; i_flush = tbl[i].flush;
         i_branch_sel = tbl[i].br; i_branch_addr = tbl[i].baddr;
         i_jump = tbl[i].jmp; i_jump_addr = tbl[i].jaddr;
         tick();
         chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_npc, tbl[i].e_halt);
      end
      set_idle();

      // HALT fetched at PC=8: freezes PC, then bubbles; flush/redirect ignored while halted.
      rst = 1'b1;
      load_word(2, HALT_WORD);
      rst = 1'b0;
      tick(); tick();
      tick();
      chk_all("halt_latch", 32'h08, HALT_WORD, 32'h0C, 1'b1);
      i_flush = 1'b1; i_branch_sel = 1'b1; i_branch_addr = 32'h40;
      tick();
      chk_all("halt_drain", 32'h08, 32'h0, 32'h0, 1'b1);
      set_idle();
      tick();
      chk_all("halt_stay", 32'h08, 32'h0, 32'h0, 1'b1);

      // Flush in the HALT-fetch cycle squashes it.
      rst = 1'b1;
      #1;
      chk_all("halt_rst", 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      rst = 1'b0;
      tick(); tick();
      i_flush = 1'b1;
      tick();
      chk_all("halt_squash", 32'h0C, 32'h0, 32'h0, 1'b0);
      i_flush = 1'b0;
      tick();
      chk_all("after_squash", 32'h10, w(3), 32'h10, 1'b0);

      // Async reset mid-run at PC=0x1C.
      rst = 1'b1;
      load_word(2, w(2));
      rst = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("pc_1c", o_current_pc, 32'h1C);
      rst = 1'b1;
      #1;
      chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      rst = 1'b0;
      tick(); tick();
      // Disabled: nothing changes except the IMEM write.
      i_enable = 1'b0; i_flush = 1'b1; i_branch_sel = 1'b1; i_branch_addr = 32'h40;
      i_load_en = 1'b1; i_load_addr = 8'd2; i_load_data = 32'hABCD_0002;
      for (int i = 0; i < 3; i++) begin
         tick();
         i_load_en = 1'b0;
         chk_all($sformatf("disabled%0d", i), 32'h08, w(1), 32'h08, 1'b0);
      end
      set_idle();
      tick();
      chk_all("load_while_off", 32'h0C, 32'hABCD_0002, 32'h0C, 1'b0);
      // Write and read of the same word on one edge returns the old word.
      i_load_en = 1'b1; i_load_addr = 8'd3; i_load_data = 32'h1234_0003;
      tick();
      i_load_en = 1'b0;
      chk_all("rd_old", 32'h10, w(3), 32'h10, 1'b0);
      i_jump = 1'b1; i_jump_addr = 32'h0C;
      tick();
      chk_all("jump_back", 32'h0C, w(4), 32'h14, 1'b0);
      i_jump = 1'b0;
      tick();
      chk_all("rd_new", 32'h10, 32'h1234_0003, 32'h10, 1'b0);

      // Randomised run against the reference model.
      set_idle();
      rst = 1'b1;
      for (int i = 0; i < 256; i++) begin
         logic [31:0] d;
         d = $urandom;
         if ($urandom_range(0, 63) == 0) d[31:26] = 6'h3F;
         else if (d[31:26] == 6'h3F) d[31:26] = 6'h01;
         i_load_en = 1'b1; i_load_addr = AW'(i); i_load_data = d;
         model_edge();
         tick();
      end
      i_load_en = 1'b0;
      rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         rst          = ($urandom_range(0, 199) == 0);
         i_enable     = ($urandom_range(0, 7) != 0);
         i_writePC    = ($urandom_range(0, 5) != 0);
         i_flush      = ($urandom_range(0, 7) == 0);
         i_branch_sel = ($urandom_range(0, 7) == 0);
         i_jump       = ($urandom_range(0, 7) == 0);
         i_branch_addr = $urandom;
         i_jump_addr   = $urandom;
         if ($urandom_range(0, 7) != 0) i_branch_addr &= 32'h3FC;
         if ($urandom_range(0, 7) != 0) i_jump_addr &= 32'h3FF;
         if ($urandom_range(0, 49) == 0) i_jump_addr = 32'hFFFF_FFFC;
         i_load_en   = ($urandom_range(0, 5) == 0);
         i_load_addr = AW'($urandom_range(0, 255));
         i_load_data = $urandom;
         if (i_load_data[31:26] == 6'h3F && $urandom_range(0, 3) != 0) i_load_data[31:26] = 6'h02;
         model_edge();
         tick();
         chk_all("rand", m_pc, m_inst, m_npc, m_halt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
